// File: rtl/vram_arbiter.sv
// VRAM arbiter: the display has fixed priority, and a starvation guard forces a CPU slot.
// Define VRAM_ARB_XOR_DRAW_EN to make CPU writes a 2-cycle XOR read-modify-write with collision.
module vram_arbiter #(
   parameter int unsigned HPOS_W       = 7,
   parameter int unsigned VPOS_W       = 6,
   parameter int unsigned PIX_W        = 2,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [HPOS_W-1:0] cpu_hpos,
   input  logic [VPOS_W-1:0] cpu_vpos,
   input  logic [PIX_W-1:0]  cpu_pixeli,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [PIX_W-1:0]  cpu_pixelo,
   output logic              cpu_collision,
   input  logic              cpu_collision_clr,
   input  logic              disp_req,
   input  logic [HPOS_W-1:0] disp_hpos,
   input  logic [VPOS_W-1:0] disp_vpos,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [PIX_W-1:0]  disp_pixelo,
   output logic [HPOS_W-1:0] vram_hpos,
   output logic [VPOS_W-1:0] vram_vpos,
   output logic [PIX_W-1:0]  vram_din,
   input  logic [PIX_W-1:0]  vram_dout,
   output logic              vram_we
);

   localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

`ifdef VRAM_ARB_XOR_DRAW_EN
   typedef enum logic {StIdle, StRmwWr} state_e;
   state_e state_q, state_d;
   logic   collision_q, collision_d;
`endif

   logic [7:0]       starve_cnt_q, starve_cnt_d;
   logic             rd_cpu_q, rd_cpu_d;
   logic             rd_disp_q, rd_disp_d;
   logic [PIX_W-1:0] cpu_pix_q, disp_pix_q;
   logic             force_cpu;
   logic             coll_set;

   assign force_cpu = cpu_req && (starve_cnt_q == StarveMax);

   always_comb begin
      cpu_gnt   = 1'b0;
      disp_gnt  = 1'b0;
      vram_hpos = '0;
      vram_vpos = '0;
      vram_din  = '0;
      vram_we   = 1'b0;
      rd_cpu_d  = 1'b0;
      rd_disp_d = 1'b0;
      coll_set  = 1'b0;
`ifdef VRAM_ARB_XOR_DRAW_EN
      state_d   = state_q;
      if (state_q == StRmwWr) begin
         // Write-back half of the XOR draw; completes even if cpu_req was dropped.
         vram_hpos = cpu_hpos;
         vram_vpos = cpu_vpos;
         vram_we   = 1'b1;
         vram_din  = vram_dout ^ cpu_pixeli;
         cpu_gnt   = 1'b1;
         coll_set  = |(vram_dout & cpu_pixeli);
         state_d   = StIdle;
      end else
`endif
      if (disp_req && !force_cpu) begin
         vram_hpos = disp_hpos;
         vram_vpos = disp_vpos;
         disp_gnt  = 1'b1;
         rd_disp_d = 1'b1;
      end else if (cpu_req) begin
         vram_hpos = cpu_hpos;
         vram_vpos = cpu_vpos;
         if (!cpu_we) begin
            cpu_gnt  = 1'b1;
            rd_cpu_d = 1'b1;
         end else begin
`ifdef VRAM_ARB_XOR_DRAW_EN
            state_d  = StRmwWr;
`else
            cpu_gnt  = 1'b1;
            vram_we  = 1'b1;
            vram_din = cpu_pixeli;
`endif
         end
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (cpu_gnt) begin
         starve_cnt_d = '0;
      end else if (cpu_req && (starve_cnt_q != StarveMax)) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

`ifdef VRAM_ARB_XOR_DRAW_EN
   // A new collision in the same cycle as a clear must not be lost.
   always_comb begin
      collision_d = collision_q;
      if (coll_set) begin
         collision_d = 1'b1;
      end else if (cpu_collision_clr) begin
         collision_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         collision_q <= collision_d;
      end
   end

   assign cpu_collision = collision_q;
`else
   logic unused_coll;
   assign unused_coll   = coll_set ^ cpu_collision_clr;
   assign cpu_collision = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
         rd_cpu_q     <= 1'b0;
         rd_disp_q    <= 1'b0;
         cpu_pix_q    <= '0;
         disp_pix_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rd_cpu_q     <= rd_cpu_d;
         rd_disp_q    <= rd_disp_d;
         if (rd_cpu_q) cpu_pix_q <= vram_dout;
         if (rd_disp_q) disp_pix_q <= vram_dout;
      end
   end

   // Read data is forwarded straight from the VRAM in the return cycle, then held.
   assign cpu_rvalid  = rd_cpu_q;
   assign disp_rvalid = rd_disp_q;
   assign cpu_pixelo  = rd_cpu_q ? vram_dout : cpu_pix_q;
   assign disp_pixelo = rd_disp_q ? vram_dout : disp_pix_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural one-cycle-read VRAM model.
// XOR-draw checks are compiled in when VRAM_ARB_XOR_DRAW_EN is defined.
module tb_vram_arbiter;

   localparam int unsigned HPOS_W = 7;
   localparam int unsigned VPOS_W = 6;
   localparam int unsigned PIX_W  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cpu_req = 1'b0, cpu_we = 1'b0;
   logic [HPOS_W-1:0] cpu_hpos = '0;
   logic [VPOS_W-1:0] cpu_vpos = '0;
   logic [PIX_W-1:0]  cpu_pixeli = '0;
   logic              cpu_gnt, cpu_rvalid, cpu_collision;
   logic [PIX_W-1:0]  cpu_pixelo;
   logic              cpu_collision_clr = 1'b0;
   logic              disp_req = 1'b0;
   logic [HPOS_W-1:0] disp_hpos = '0;
   logic [VPOS_W-1:0] disp_vpos = '0;
   logic              disp_gnt, disp_rvalid;
   logic [PIX_W-1:0]  disp_pixelo;
   logic [HPOS_W-1:0] vram_hpos;
   logic [VPOS_W-1:0] vram_vpos;
   logic [PIX_W-1:0]  vram_din;
   logic [PIX_W-1:0]  vram_dout = '0;
   logic              vram_we;

   logic [PIX_W-1:0]  mem [0:(1<<(HPOS_W+VPOS_W))-1];
   logic              pre_we = 1'b0;
   logic [HPOS_W+VPOS_W-1:0] pre_addr = '0;
   logic [PIX_W-1:0]  pre_data = '0;

   int n_checks = 0;
   int n_errors = 0;

   vram_arbiter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cpu_req           (cpu_req),
      .cpu_we            (cpu_we),
      .cpu_hpos          (cpu_hpos),
      .cpu_vpos          (cpu_vpos),
      .cpu_pixeli        (cpu_pixeli),
      .cpu_gnt           (cpu_gnt),
      .cpu_rvalid        (cpu_rvalid),
      .cpu_pixelo        (cpu_pixelo),
      .cpu_collision     (cpu_collision),
      .cpu_collision_clr (cpu_collision_clr),
      .disp_req          (disp_req),
      .disp_hpos         (disp_hpos),
      .disp_vpos         (disp_vpos),
      .disp_gnt          (disp_gnt),
      .disp_rvalid       (disp_rvalid),
      .disp_pixelo       (disp_pixelo),
      .vram_hpos         (vram_hpos),
      .vram_vpos         (vram_vpos),
      .vram_din          (vram_din),
      .vram_dout         (vram_dout),
      .vram_we           (vram_we)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (vram_we) mem[{vram_vpos, vram_hpos}] <= vram_din;
      vram_dout <= mem[{vram_vpos, vram_hpos}];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int h, input int v, input int d);
      pre_we   = 1'b1;
      pre_addr = {VPOS_W'(v), HPOS_W'(h)};
      pre_data = PIX_W'(d);
      next_cycle();
      pre_we   = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_cpu_gnt"}, 32'(cpu_gnt), 0);
      check_eq({tag, "_disp_gnt"}, 32'(disp_gnt), 0);
      check_eq({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
      check_eq({tag, "_disp_rvalid"}, 32'(disp_rvalid), 0);
      check_eq({tag, "_vram_we"}, 32'(vram_we), 0);
      check_eq({tag, "_vram_addr"}, 32'({vram_vpos, vram_hpos}), 0);
      check_eq({tag, "_collision"}, 32'(cpu_collision), 0);
   endtask

`ifdef VRAM_ARB_XOR_DRAW_EN
   task automatic rmw_write(input string tag, input int h, input int v, input int p,
                            input logic clr, input int exp_din, input int exp_coll);
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_hpos = HPOS_W'(h); cpu_vpos = VPOS_W'(v); cpu_pixeli = PIX_W'(p);
      @(negedge clk);
      check_eq({tag, "_a_gnt"}, 32'(cpu_gnt), 0);
      check_eq({tag, "_a_we"}, 32'(vram_we), 0);
      next_cycle();
      cpu_collision_clr = clr;
      disp_req = 1'b1;
      @(negedge clk);
      check_eq({tag, "_b_we"}, 32'(vram_we), 1);
      check_eq({tag, "_b_din"}, 32'(vram_din), 32'(exp_din));
      check_eq({tag, "_b_gnt"}, 32'(cpu_gnt), 1);
      check_eq({tag, "_b_disp_gnt"}, 32'(disp_gnt), 0);
      next_cycle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_collision_clr = 1'b0; disp_req = 1'b0;
      @(negedge clk);
      check_eq({tag, "_coll"}, 32'(cpu_collision), 32'(exp_coll));
      check_eq({tag, "_mem"}, 32'(mem[{VPOS_W'(v), HPOS_W'(h)}]), 32'(exp_din));
      next_cycle();
   endtask
`endif

   initial begin
      preload(5, 3, 3);
      preload(1, 1, 2);
      preload(10, 4, 3);
      preload(12, 5, 1);
      preload(7, 2, 0);
      @(negedge clk);
      check_idle_outputs("reset");
      check_eq("reset_cpu_pixelo", 32'(cpu_pixelo), 0);
      check_eq("reset_disp_pixelo", 32'(disp_pixelo), 0);
      check_eq("reset_starve", 32'(dut.starve_cnt_q), 0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // Uncontended CPU read of (5,3)
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd5; cpu_vpos = 6'd3;
      @(negedge clk);
      check_eq("rd_gnt", 32'(cpu_gnt), 1);
      check_eq("rd_addr", 32'({vram_vpos, vram_hpos}), 32'({6'd3, 7'd5}));
      check_eq("rd_we", 32'(vram_we), 0);
      next_cycle();
      cpu_req = 1'b0;
      @(negedge clk);
      check_eq("rd_rvalid", 32'(cpu_rvalid), 1);
      check_eq("rd_pixelo", 32'(cpu_pixelo), 3);
      check_eq("rd_disp_rvalid", 32'(disp_rvalid), 0);
      next_cycle();

      // Contention, then the forced CPU slot once starve_cnt reaches 16
      disp_req = 1'b1; disp_hpos = 7'd1; disp_vpos = 6'd1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd5; cpu_vpos = 6'd3;
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         if (i < 16) begin
            check_eq($sformatf("cont%0d_disp_gnt", i), 32'(disp_gnt), 1);
            check_eq($sformatf("cont%0d_cpu_gnt", i), 32'(cpu_gnt), 0);
         end else begin
            check_eq("starve_cpu_gnt", 32'(cpu_gnt), 1);
            check_eq("starve_disp_gnt", 32'(disp_gnt), 0);
            check_eq("starve_addr", 32'({vram_vpos, vram_hpos}), 32'({6'd3, 7'd5}));
            check_eq("starve_cnt16", 32'(dut.starve_cnt_q), 16);
         end
         if (i == 1) begin
            check_eq("cont_disp_rvalid", 32'(disp_rvalid), 1);
            check_eq("cont_disp_pixelo", 32'(disp_pixelo), 2);
         end
         if (i == 3) check_eq("cont_starve3", 32'(dut.starve_cnt_q), 3);
         next_cycle();
         if (i == 16) cpu_req = 1'b0;
      end
      @(negedge clk);
      check_eq("post_starve_cnt", 32'(dut.starve_cnt_q), 0);
      check_eq("post_disp_gnt", 32'(disp_gnt), 1);
      check_eq("post_cpu_rvalid", 32'(cpu_rvalid), 1);
      check_eq("post_cpu_pixelo", 32'(cpu_pixelo), 3);
      check_eq("post_disp_rvalid", 32'(disp_rvalid), 0);
      check_eq("post_disp_hold", 32'(disp_pixelo), 2);
      next_cycle();
      disp_req = 1'b0;
      next_cycle();
      @(negedge clk);
      check_idle_outputs("idle");

`ifdef VRAM_ARB_XOR_DRAW_EN
      next_cycle();
      rmw_write("xor1", 10, 4, 3, 1'b0, 0, 1);
      rmw_write("xor2", 10, 4, 3, 1'b0, 3, 1);
      cpu_collision_clr = 1'b1;
      next_cycle();
      cpu_collision_clr = 1'b0;
      @(negedge clk);
      check_eq("clr_only", 32'(cpu_collision), 0);
      next_cycle();
      rmw_write("xor3", 10, 4, 3, 1'b1, 0, 1);

      // Reset dropped into cycle B of a write to (12,5)
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_hpos = 7'd12; cpu_vpos = 6'd5; cpu_pixeli = 2'd2;
      next_cycle();
      @(negedge clk);
      check_eq("rst_b_we", 32'(vram_we), 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_we_drop", 32'(vram_we), 0);
      check_eq("rst_gnt_drop", 32'(cpu_gnt), 0);
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_hpos = '0; cpu_vpos = '0; cpu_pixeli = '0;
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_mem", 32'(mem[{6'd5, 7'd12}]), 1);
      check_idle_outputs("rst_rel");
      check_eq("rst_rel_cpu_pixelo", 32'(cpu_pixelo), 0);
      check_eq("rst_rel_disp_pixelo", 32'(disp_pixelo), 0);
`else
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_hpos = 7'd7; cpu_vpos = 6'd2; cpu_pixeli = 2'd2;
      @(negedge clk);
      check_eq("wr_gnt", 32'(cpu_gnt), 1);
      check_eq("wr_we", 32'(vram_we), 1);
      check_eq("wr_din", 32'(vram_din), 2);
      check_eq("wr_addr", 32'({vram_vpos, vram_hpos}), 32'({6'd2, 7'd7}));
      check_eq("wr_coll", 32'(cpu_collision), 0);
      next_cycle();
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk);
      check_eq("wr_no_rvalid", 32'(cpu_rvalid), 0);
      check_eq("wr_mem", 32'(mem[{6'd2, 7'd7}]), 2);
      check_eq("wr_we_off", 32'(vram_we), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
